// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters. One
// transaction is in flight at a time and walks IDLE -> EXEC -> RESP:
//   IDLE : grant one valid requester (round-robin or fixed priority to port 0),
//          capture its operands, opcode and owner id on the handshake.
//   EXEC : drive the captured operands/opcode onto the ALU and capture
//          alu_out into rsp_data at the closing edge.
//   RESP : present rsp_data to the owner and wait for its rsp_ready.
//
// Parameters
//   WIDTH : operand/result width
//   RR_EN : 1 = round-robin on ties, 0 = port 0 always wins ties
//
// Ports
//   clk, rst_n                 : rising-edge clock, async active-low reset
//   reqN_valid / reqN_ready    : request handshake, port N (N = 0, 1)
//   reqN_A, reqN_B, reqN_op    : operands and ALU opcode of port N
//   alu_A, alu_B, alu_op       : drive to the shared ALU
//   alu_out                    : combinational result of the shared ALU
//   rspN_valid / rspN_ready    : response handshake, port N
//   rsp_data                   : result for the owning port
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter bit RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic [3:0]       req0_op,
    input  logic [3:0]       req1_op,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data
);

    // "Don't care" opcode of the shared ALUop header, driven whenever the
    // ALU is not in use.
    localparam logic [3:0] ALU_XXX = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, rsp_data_q;
    logic [3:0]       op_q;
    logic             owner_q;      // port id of the transaction in flight
    logic             last_grant_q; // port granted most recently
    logic             grant;        // port that would win this IDLE cycle
    logic             accept;       // handshake happens at the next edge

    // Grant is recomputed every IDLE cycle from the current valids, so a
    // request that drops valid before being accepted is simply never granted.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = RR_EN ? ~last_grant_q : 1'b0;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign accept     = (state_q == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant;
    assign req1_ready = accept &&  grant;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            // Only the owner's rsp_ready can close the transaction; the
            // completing cycle is RESP, so no request is accepted in it.
            RESP:    if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // last_grant resets to 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_data_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            if (accept) begin
                a_q          <= grant ? req1_A  : req0_A;
                b_q          <= grant ? req1_B  : req0_B;
                op_q         <= grant ? req1_op : req0_op;
                owner_q      <= grant;
                last_grant_q <= grant;
            end
            if (state_q == EXEC) begin
                rsp_data_q <= alu_out;
            end
        end
    end

    // The ALU sees live operands only during EXEC; zeros and ALU_XXX
    // otherwise keep it quiet and make idle cycles obvious on a waveform.
    assign alu_A      = (state_q == EXEC) ? a_q  : '0;
    assign alu_B      = (state_q == EXEC) ? b_q  : '0;
    assign alu_op     = (state_q == EXEC) ? op_q : ALU_XXX;

    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) &&  owner_q;
    assign rsp_data   = rsp_data_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 The block SHALL have parameter RR_EN, default 1; 1 = round-robin grant, 0 = fixed priority to port 0.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have ports req0_valid/req1_valid  input  1 each  request present.
REQ-006 The block SHALL have ports req0_ready/req1_ready  output  1 each  request accepted this cycle.
REQ-007 The block SHALL have ports req0_A, req0_B, req1_A, req1_B  input  WIDTH each  operands.
REQ-008 The block SHALL have ports req0_op/req1_op  input  4 each  ALU operation code from the shared ALUop header.
REQ-009 The block SHALL have ports alu_A, alu_B  output  WIDTH each, and alu_op  output  4, driving the shared ALU.
REQ-010 The block SHALL have port alu_out  input  WIDTH  combinational result of the shared ALU.
REQ-011 The block SHALL have ports rsp0_valid/rsp1_valid  output  1 each, rsp0_ready/rsp1_ready  input  1 each, rsp_data  output  WIDTH  result to the owning port.

Function
REQ-012 The block SHALL use three states: IDLE, EXEC, RESP; at most one transaction outstanding.
REQ-013 In IDLE the block SHALL assert exactly one reqN_ready, and only to the granted port whose reqN_valid is high; both readies SHALL be low in EXEC and RESP.
REQ-014 Grant SHALL be combinational in IDLE: single valid port wins; both valid with RR_EN=1 -> port other than last_grant; RR_EN=0 -> port 0.
REQ-015 On handshake (valid & ready) the block SHALL register A, B, op and owner id, update last_grant to the owner, and move to EXEC.
REQ-016 In EXEC alu_A/alu_B/alu_op SHALL equal the registered values; at the clock edge alu_out SHALL be captured into rsp_data and state moves to RESP.
REQ-017 In IDLE and RESP alu_op SHALL drive the ALU_XXX code and alu_A/alu_B SHALL be 0.
REQ-018 In RESP the block SHALL assert rspN_valid only for the owner, hold rsp_data stable, and return to IDLE on the edge where rspN_ready is high.
REQ-019 Latency SHALL be: handshake at edge N, ALU driven during cycle N+1, rspN_valid high from edge N+2; a new request SHALL NOT be accepted in the cycle rsp completes (back-to-back throughput one op per 3 cycles minimum).
REQ-020 Operand codes SHALL pass through unmodified; the block SHALL NOT interpret op values or check arithmetic.
REQ-021 rspN_ready asserted while rspN_valid is low SHALL be ignored; the non-owner's rsp_ready SHALL be ignored.
REQ-022 A request deasserting valid before handshake SHALL NOT be granted; grant SHALL re-evaluate every IDLE cycle.
REQ-023 Simultaneous arrival of both requests SHALL serve both in RR order without loss, holding the loser's ready low until the next IDLE.

Reset
REQ-024 While rst_n is low all state SHALL clear immediately: state=IDLE, last_grant=1 (port 0 wins first tie), rsp_data=0, registered operands=0, both rspN_valid=0.
REQ-025 Reset asserted in EXEC or RESP SHALL abort the transaction with no response issued; after release the block SHALL accept new requests on the first edge.

Verification
REQ-026 req0 only, A=5, B=3, op=ADD, rsp0_ready=1 -> req0_ready high cycle 0, alu_op=ADD in cycle 1, rsp0_valid with rsp_data=8 from edge 2, IDLE at edge 3.
REQ-027 Both valid continuously after reset, RR_EN=1, req0 SUB 10-4, req1 XOR 0xF0^0x0F -> port 0 first (rsp_data=6), then port 1 (rsp_data=0xFF), alternating thereafter.
REQ-028 Same stimulus with RR_EN=0 -> only port 0 ever granted while req0_valid stays high.
REQ-029 rsp1_ready held low 5 cycles in RESP -> rsp1_valid and rsp_data stable, both req readies low, alu_op=ALU_XXX throughout.
REQ-030 rst_n dropped mid-EXEC -> all outputs at reset values immediately; no rsp_valid after release; next request completes normally.
REQ-031 SRA with A=0x80000000, B=4 -> rsp_data=0xF8000000 (pass-through of shared ALU result).
